prog_mem_loadable: RTL and testbench
====================================

// Module: prog_mem_loadable
// PURPOSE
//  Parametrised, run-time loadable program memory for the microcontroller core.
//  A loader streams instruction words in over a valid/ready port; the fetch unit then reads them.
//  Reads are registered: 1-cycle latency, with a valid strobe.
//  Output line = {addr, word}, matching the existing fetch/decode line format.
// PARAMETERS
//  DATA_W  42           instruction word width ({2b,4b op,12b,12b,12b})
//  ADDR_W  4            address width; DEPTH = 1<<ADDR_W words
//  NOP_W   {DATA_W{0}}  word returned on out-of-range fetch (opcode 0 = nop)
// PORTS
//  clk         in   1             clock; all state updates on posedge
//  rst         in   1             reset; asynchronous, active-high
//  ld_valid    in   1             loader word present
//  ld_ready    out  1             loader word accepted when ld_valid&&ld_ready
//  ld_data     in   DATA_W        instruction word to store
//  ld_last     in   1             qualifies final word of a program
//  ld_abort    in   1             pulse: discard program, return to EMPTY
//  fetch_req   in   1             fetch request, sampled when fetch_ready
//  fetch_addr  in   ADDR_W        fetch address
//  fetch_ready out  1             fetch accepted this cycle
//  line_valid  out  1             line holds a fetched word (1 cycle after accept)
//  line        out  ADDR_W+DATA_W {fetch_addr, word}
//  fetch_oob   out  1             with line_valid: fetch_addr >= prog_len
//  prog_len    out  ADDR_W+1      words in loaded program (0..DEPTH)
//  running     out  1             state==RUN
//  ld_err      out  1             state==OVF
// BEHAVIOUR
//  Reset values: state=EMPTY, wr_ptr=0, prog_len=0. All outputs 0, except ld_ready=1.
//    RAM contents are not reset.
//  FSM:
//    EMPTY->LOAD on accepted ld_valid.
//    LOAD->RUN on accepted word with ld_last; prog_len<=wr_ptr+1.
//    LOAD->OVF on accepted word at wr_ptr==DEPTH-1 without ld_last.
//    RUN->LOAD on accepted ld_valid. This is a reload: wr_ptr restarts at 0, prog_len<=0.
//    ld_abort from any state -> EMPTY, wr_ptr=0, prog_len=0. ld_abort has priority over ld_valid.
//  Writes: every accepted word goes to mem[wr_ptr]; wr_ptr++ afterwards.
//    An accepted ld_last in EMPTY/RUN starts a 1-word program; prog_len=1.
//  ld_ready = (state!=OVF). In OVF all load words are refused until ld_abort.
//  fetch_ready = (state==RUN) && !ld_valid. A load always wins over a simultaneous fetch.
//  Fetch accepted at cycle N -> at cycle N+1: line_valid=1, line={addr,mem[addr]}.
//    If addr >= prog_len: fetch_oob=1 and word=NOP_W.
//  No accept at N -> line_valid=0 at N+1; line holds its last value.
//  Fetch of a word written in the same cycle: impossible by construction, since fetch_ready=0 while ld_valid.
//  Reset asserted mid-load or mid-fetch: immediate return to reset values; the partial program is lost.
// CONFIGURATION
//  PROG_MEM_PARITY_EN defined:
//    - RAM stores DATA_W+1 bits; even parity is computed on write.
//    - Extra output line_perr (1b) is asserted with line_valid on a parity mismatch.
//    - line_perr is never asserted for oob fetches. Reset value 0.
//  PROG_MEM_PARITY_EN undefined: no parity bit, no line_perr port.
// STRUCTURE
//  Package prog_mem_pkg contains:
//    - state enum {EMPTY,LOAD,RUN,OVF}
//    - opcode field offsets/widths
//    - OP_NOP, OP_MOV, OP_JMP, OP_NOT constants
//    - default NOP word
//  One sub-module, prog_mem_ram: simple dual-port array with sync write and sync read, width/depth parametrised.
//  Control, FSM and oob/parity logic stay in prog_mem_loadable.
// TESTING
//  1 Reset, fetch_req=1 addr 0 -> fetch_ready=0, line_valid=0, prog_len=0, ld_ready=1.
//  2 Load 4 words (w0={2'h0,4'h1,12'd150,12'h801,12'd0}, w3={2'h0,4'h2,12'd1,24'd0}, ld_last on w3),
//    then fetch 0..3 -> running=1, prog_len=4.
//    Each line_valid arrives 1 cycle after its accept, and line[45:42] = the address.
//  3 After test 2, fetch addr 9 -> line_valid=1, fetch_oob=1, line={4'd9,42'd0}.
//  4 Stream 16 words with no ld_last -> ld_err=1, ld_ready=0, fetch_ready=0.
//    Then pulse ld_abort -> EMPTY; ld_ready=1.
//  5 In RUN, assert ld_valid and fetch_req together -> word written at addr 0, fetch_ready=0.
//    Next cycle line_valid=0; state=LOAD, prog_len=0.
//  6 Assert rst mid-load after 2 words -> prog_len=0, running=0 immediately.
//    (PARITY_EN) Force a RAM bit flip, then fetch that word -> line_perr=1.

Source files
------------

// File: rtl/prog_mem_pkg.sv
// Shared types and instruction-format constants for the loadable program memory.
// Instruction word: {2b, 4b op, 12b, 12b, 12b}.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StLoad,
        StRun,
        StOvf
    } prog_state_e;

    localparam int unsigned INSN_W  = 42;
    localparam int unsigned OP_LSB  = 36;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned FIELD_W = 12;
    localparam int unsigned FA_LSB  = 24;
    localparam int unsigned FB_LSB  = 12;
    localparam int unsigned FC_LSB  = 0;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_MOV = 4'h1;
    localparam logic [OP_W-1:0] OP_JMP = 4'h2;
    localparam logic [OP_W-1:0] OP_NOT = 4'h3;

    localparam logic [INSN_W-1:0] NOP_WORD = '0;

    function automatic logic [OP_W-1:0] insn_op(input logic [INSN_W-1:0] w);
        return w[OP_LSB +: OP_W];
    endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read with a hold-on-idle read register.
// Array contents are not reset; only the read register is.
module prog_mem_ram #(
    parameter int unsigned WIDTH  = 42,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_d, rd_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rd_d = rd_q;
        if (re_i) begin
            rd_d = mem_q[raddr_i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/prog_mem_loadable.sv
// Run-time loadable program memory: valid/ready loader port plus registered fetch port.
// Define PROG_MEM_PARITY_EN to store an even-parity bit per word and expose line_perr.
module prog_mem_loadable
    import prog_mem_pkg::*;
#(
    parameter int unsigned       DATA_W = INSN_W,
    parameter int unsigned       ADDR_W = 4,
    parameter logic [DATA_W-1:0] NOP_W  = DATA_W'(NOP_WORD)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic                     ld_last,
    input  logic                     ld_abort,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    output logic                     line_valid,
    output logic [ADDR_W+DATA_W-1:0] line,
    output logic                     fetch_oob,
    output logic [ADDR_W:0]          prog_len,
    output logic                     running,
    output logic                     ld_err
`ifdef PROG_MEM_PARITY_EN
    ,
    output logic                     line_perr
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned RAM_W = DATA_W + PAR_W;

    prog_state_e       state_d, state_q;
    logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_W:0]   prog_len_d, prog_len_q;
    logic              line_valid_d, line_valid_q;
    logic [ADDR_W-1:0] line_addr_d, line_addr_q;
    logic              oob_d, oob_q;

    logic              ld_acc, fetch_acc;
    logic [ADDR_W-1:0] wr_addr;
    logic [RAM_W-1:0]  wr_data, rd_data;

    always_comb begin
        ld_ready    = (state_q != StOvf);
        ld_acc      = ld_valid && ld_ready && !ld_abort;
        fetch_ready = (state_q == StRun) && !ld_valid;
        fetch_acc   = fetch_req && fetch_ready;
        // Only an ongoing load continues at wr_ptr; a load from EMPTY or RUN starts at 0.
        wr_addr     = (state_q == StLoad) ? wr_ptr_q : '0;
    end

`ifdef PROG_MEM_PARITY_EN
    assign wr_data = {^ld_data, ld_data};
`else
    assign wr_data = ld_data;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        if (ld_abort) begin
            state_d    = StEmpty;
            wr_ptr_d   = '0;
            prog_len_d = '0;
        end else if (ld_acc) begin
            wr_ptr_d = wr_addr + ADDR_W'(1);
            unique case (state_q)
                StLoad: begin
                    if (ld_last) begin
                        state_d    = StRun;
                        prog_len_d = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
                    end else if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = StOvf;
                    end
                end
                default: begin
                    state_d    = ld_last ? StRun : StLoad;
                    prog_len_d = ld_last ? (ADDR_W + 1)'(1) : '0;
                end
            endcase
        end
    end

    always_comb begin
        line_valid_d = fetch_acc;
        line_addr_d  = line_addr_q;
        oob_d        = oob_q;
        if (fetch_acc) begin
            line_addr_d = fetch_addr;
            oob_d       = ({1'b0, fetch_addr} >= prog_len_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            line_valid_q <= 1'b0;
            line_addr_q  <= '0;
            oob_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_len_q   <= prog_len_d;
            line_valid_q <= line_valid_d;
            line_addr_q  <= line_addr_d;
            oob_q        <= oob_d;
        end
    end

    prog_mem_ram #(
        .WIDTH  (RAM_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (ld_acc),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (fetch_acc),
        .raddr_i (fetch_addr),
        .rdata_o (rd_data)
    );

    assign line_valid = line_valid_q;
    assign line       = {line_addr_q, oob_q ? NOP_W : rd_data[DATA_W-1:0]};
    assign fetch_oob  = line_valid_q && oob_q;
    assign prog_len   = prog_len_q;
    assign running    = (state_q == StRun);
    assign ld_err     = (state_q == StOvf);

`ifdef PROG_MEM_PARITY_EN
    assign line_perr  = line_valid_q && !oob_q && (^rd_data);
`endif

endmodule

// File: tb/tb_prog_mem_loadable.sv
// Scoreboard bench for prog_mem_loadable: fetches push expected lines, a negedge monitor checks them.
module tb_prog_mem_loadable;

    localparam int DW = 42;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_ready, ld_last, ld_abort;
    logic [DW-1:0] ld_data;
    logic          fetch_req, fetch_ready;
    logic [AW-1:0] fetch_addr;
    logic          line_valid, fetch_oob, running, ld_err;
    logic [AW+DW-1:0] line;
    logic [AW:0]   prog_len;
`ifdef PROG_MEM_PARITY_EN
    logic          line_perr;
`endif

    prog_mem_loadable dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_abort    (ld_abort),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .line_valid  (line_valid),
        .line        (line),
        .fetch_oob   (fetch_oob),
        .prog_len    (prog_len),
        .running     (running),
        .ld_err      (ld_err)
`ifdef PROG_MEM_PARITY_EN
        ,
        .line_perr   (line_perr)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW+DW-1:0] line;
        logic             oob;
        logic             perr;
        int               cyc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] w, input logic oob,
                         input logic perr);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = a;
        #1;
        chk("fetch_ready", fetch_ready, 1);
        e.line = {a, w};
        e.oob  = oob;
        e.perr = perr;
        e.cyc  = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && line_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL line_unexpected: got line %0h expected no line_valid", line);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("line", line, e.line);
                chk("line_addr", line[AW+DW-1:DW], e.line[AW+DW-1:DW]);
                chk("fetch_oob", fetch_oob, e.oob);
                chk("line_latency", cyc, e.cyc);
`ifdef PROG_MEM_PARITY_EN
                chk("line_perr", line_perr, e.perr);
`endif
            end
        end
    end

    logic [DW-1:0] w [4];
    logic [DW-1:0] a0, a1, b0, b1, x0, q0, q1, qf;

    initial begin
        w[0] = {2'h0, 4'h1, 12'd150, 12'h801, 12'd0};
        w[1] = {2'h1, 4'h3, 12'h0ab, 12'h0cd, 12'h0ef};
        w[2] = {2'h2, 4'h1, 12'd7, 12'd8, 12'd9};
        w[3] = {2'h0, 4'h2, 12'd1, 24'd0};
        a0 = {2'h3, 4'h1, 12'h111, 12'h222, 12'h333};
        a1 = {2'h1, 4'h2, 12'h444, 12'h555, 12'h666};
        b0 = {2'h2, 4'h3, 12'h777, 12'h888, 12'h999};
        b1 = {2'h0, 4'h1, 12'haaa, 12'hbbb, 12'hccc};
        x0 = {2'h1, 4'h0, 12'hfff, 12'h000, 12'h123};
        q0 = {2'h0, 4'h1, 12'h00f, 12'h0f0, 12'hf00};
        q1 = {2'h3, 4'h3, 12'h5a5, 12'ha5a, 12'h3c3};

        rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_abort = 1'b0; ld_data = '0;
        fetch_req = 1'b1; fetch_addr = '0;

        // 1: reset state
        step(); step();
        chk("rst_fetch_ready", fetch_ready, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_running", running, 0);
        chk("rst_ld_err", ld_err, 0);
        chk("rst_line", line, 0);
        rst = 1'b0;
        step();
        chk("empty_fetch_ready", fetch_ready, 0);
        fetch_req = 1'b0;

        // 2: load 4 words, fetch them back
        for (int i = 0; i < 4; i++) load_word(w[i], i == 3);
        chk("t2_running", running, 1);
        chk("t2_prog_len", prog_len, 4);
        for (int i = 0; i < 4; i++) fetch(AW'(i), w[i], 1'b0, 1'b0);

        // 3: out-of-range fetches
        fetch(4'd9, '0, 1'b1, 1'b0);
        fetch(4'd4, '0, 1'b1, 1'b0);
        step();
        chk("t3_line_hold", line, {4'd4, 42'd0});
        chk("t3_idle_valid", line_valid, 0);

        // 4: overflow then abort
        for (int i = 0; i < 16; i++) load_word(DW'(i + 100), 1'b0);
        chk("t4_ld_err", ld_err, 1);
        chk("t4_ld_ready", ld_ready, 0);
        fetch_req = 1'b1;
        #1;
        chk("t4_fetch_ready", fetch_ready, 0);
        fetch_req = 1'b0;
        load_word(DW'(555), 1'b1);
        chk("t4_refused", ld_err, 1);
        ld_abort = 1'b1;
        step();
        ld_abort = 1'b0;
        chk("t4_abort_ld_ready", ld_ready, 1);
        chk("t4_abort_ld_err", ld_err, 0);
        chk("t4_abort_prog_len", prog_len, 0);

        // abort wins over a simultaneous load word
        ld_abort = 1'b1;
        load_word(DW'(777), 1'b0);
        ld_abort = 1'b0;
        load_word(x0, 1'b1);
        chk("abort_prio_prog_len", prog_len, 1);
        chk("abort_prio_running", running, 1);
        fetch(4'd0, x0, 1'b0, 1'b0);
        fetch(4'd1, '0, 1'b1, 1'b0);

        // 5: load beats fetch in RUN
        load_word(a0, 1'b0);
        load_word(a1, 1'b1);
        chk("t5_prog_len_a", prog_len, 2);
        ld_valid = 1'b1; ld_data = b0; ld_last = 1'b0;
        fetch_req = 1'b1; fetch_addr = 4'd1;
        #1;
        chk("t5_fetch_ready", fetch_ready, 0);
        @(posedge clk);
        #1;
        ld_valid = 1'b0; fetch_req = 1'b0;
        chk("t5_line_valid", line_valid, 0);
        chk("t5_running", running, 0);
        chk("t5_prog_len", prog_len, 0);
        load_word(b1, 1'b1);
        chk("t5_prog_len_b", prog_len, 2);
        fetch(4'd0, b0, 1'b0, 1'b0);
        fetch(4'd1, b1, 1'b0, 1'b0);
        fetch(4'd2, '0, 1'b1, 1'b0);

        // 6: reset mid-load and mid-fetch
        load_word(q0, 1'b0);
        load_word(q1, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_prog_len", prog_len, 0);
        chk("t6_running", running, 0);
        chk("t6_ld_ready", ld_ready, 1);
        step();
        rst = 1'b0;
        load_word(q0, 1'b0);
        load_word(q1, 1'b1);
        chk("t6_reload_len", prog_len, 2);
        fetch_req = 1'b1; fetch_addr = 4'd0;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_fetch_rst_running", running, 0);
        chk("t6_fetch_rst_len", prog_len, 0);
        chk("t6_fetch_rst_ready", fetch_ready, 0);
        step();
        rst = 1'b0; fetch_req = 1'b0;

`ifdef PROG_MEM_PARITY_EN
        load_word(q0, 1'b0);
        load_word(q1, 1'b1);
        dut.u_ram.mem_q[1][3] = ~dut.u_ram.mem_q[1][3];
        qf = q1;
        qf[3] = ~qf[3];
        fetch(4'd0, q0, 1'b0, 1'b0);
        fetch(4'd1, qf, 1'b0, 1'b1);
        fetch(4'd5, '0, 1'b1, 1'b0);
`endif

        step(); step(); step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending lines expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
